uart_key_mapper: RTL and testbench
==================================

UART_KEY_MAPPER -- requirements
Module: uart_key_mapper

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of remotely controlled paddles, legal range 1..4.
REQ-002 SHALL have parameter UP_CODES, default {8'h69,8'h77}: byte codes for "up", player p at bits [8p+7:8p].
REQ-003 SHALL have parameter DOWN_CODES, default {8'h6B,8'h73}: byte codes for "down", same packing as UP_CODES.
REQ-004 SHALL have parameter HOLD_FRAMES, default 3: number of frame ticks a key stays asserted after its last matching byte, legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx_empty, input, 1 bit: UART receive FIFO empty flag.
REQ-008 SHALL have port rd_data, input, 8 bits: UART FIFO head byte, first-word-fall-through, valid while rx_empty=0.
REQ-009 SHALL have port rd_uart, output, 1 bit: one-cycle FIFO pop strobe.
REQ-010 SHALL have port frame_tick, input, 1 bit: one-cycle pulse once per video frame.
REQ-011 SHALL have port keys, output, 2*NUM_PLAYERS bits: player p at bits [2p+1:2p] = {down,up}.
REQ-012 SHALL have port unknown_cnt, output, 8 bits: saturating count of bytes matching no code.
REQ-013 SHALL have port byte_seen, output, 1 bit: one-cycle pulse when any byte is decoded.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and DECODE.
REQ-015 In IDLE with rx_empty=0, SHALL assert rd_uart for exactly that cycle, register rd_data into byte_reg, and move to DECODE.
REQ-016 In IDLE with rx_empty=1, SHALL keep rd_uart=0 and stay in IDLE.
REQ-017 In DECODE, SHALL compare byte_reg against every UP_CODES and DOWN_CODES entry, pulse byte_seen, and return to IDLE; throughput is at most one byte per 2 cycles.
REQ-018 On a match for player p, SHALL load dir_p with 2'b01 for up or 2'b10 for down, and load hold_p with HOLD_FRAMES.
REQ-019 When a byte matches codes of several players, SHALL update all matching players; when a byte matches both up and down of one player, up SHALL win.
REQ-020 When a byte matches no code, SHALL increment unknown_cnt, saturating at 255; no key state SHALL change.
REQ-021 On frame_tick, SHALL decrement each nonzero hold_p by 1; hold_p SHALL never wrap below 0.
REQ-022 When frame_tick and a match for player p occur in the same cycle, the load SHALL win for p; other players SHALL still decrement.
REQ-023 keys[2p+1:2p] SHALL equal dir_p when hold_p != 0, else 2'b00; the output SHALL be registered, changing one cycle after the hold/dir update.
REQ-024 A new opposite-direction byte SHALL replace dir_p immediately, so keys never show 2'b11.
REQ-025 A frame_tick arriving while the FSM is in DECODE or IDLE SHALL be honoured; no tick SHALL be lost.

Reset
REQ-026 While reset=1, SHALL force: FSM to IDLE, rd_uart=0, byte_seen=0, byte_reg=0, all dir_p=0, all hold_p=0, keys=0, unknown_cnt=0.
REQ-027 Reset asserted mid-DECODE SHALL discard the captured byte; after release, the FSM SHALL resume in IDLE and pop only the next non-empty FIFO head.

Verification
REQ-028 Byte 0x77 in FIFO -> rd_uart high for 1 cycle, keys=4'b0001 two cycles later, held through 2 ticks, 4'b0000 after the 3rd tick.
REQ-029 0x73 then 0x69 back-to-back -> keys=4'b0010 then 4'b0110; pops spaced exactly 2 cycles apart.
REQ-030 0x77 then 0x73 before any tick -> player 0 bits go 01 then 10, never 11; hold reloaded to 3.
REQ-031 0x41 x 300 -> unknown_cnt saturates at 255, keys stay 0.
REQ-032 Match for player 1 coincident with frame_tick while player 0 hold=2 -> player 1 hold=3, player 0 hold=1.
REQ-033 Reset pulsed while in DECODE holding 0x77 -> keys stay 0 after release, FSM in IDLE, no spurious rd_uart with rx_empty=1.

Source files
------------

// File: rtl/uart_key_mapper.sv
// uart_key_mapper: pulls bytes from a first-word-fall-through UART receive
// FIFO and turns them into per-player {down,up} key levels. Each recognised
// byte holds its key for HOLD_FRAMES frame ticks; bytes that match no code
// are counted in a saturating counter.
//
// FIFO handshake: the FIFO presents a valid head byte whenever rx_empty=0.
// rd_uart is a one-cycle pop strobe, raised only in IDLE while rx_empty=0.
// The byte on rd_data is consumed on the same rising edge that rd_uart is
// high, so capture and pop happen together.
module uart_key_mapper #(
  parameter int                         NUM_PLAYERS = 2,
  parameter logic [8*NUM_PLAYERS-1:0]   UP_CODES    = {8'h69, 8'h77},
  parameter logic [8*NUM_PLAYERS-1:0]   DOWN_CODES  = {8'h6B, 8'h73},
  parameter int                         HOLD_FRAMES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_empty,
  input  logic [7:0]                 rd_data,
  output logic                       rd_uart,
  input  logic                       frame_tick,
  output logic [2*NUM_PLAYERS-1:0]   keys,
  output logic [7:0]                 unknown_cnt,
  output logic                       byte_seen,
  output logic                       state_dbg
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

  typedef enum logic {
    IDLE   = 1'b0,
    DECODE = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            byte_reg;
  logic [7:0]            hold_q [NUM_PLAYERS];
  logic [1:0]            dir_q  [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] up_hit;
  logic [NUM_PLAYERS-1:0] dn_hit;
  logic                  any_hit;
  logic                  decode_en;

  assign state_dbg = state_q;
  assign decode_en = (state_q == DECODE);

  // State register; reset always lands in IDLE so a half-decoded byte is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes: pop in IDLE when data is present, decode for one cycle.
  always_comb begin
    state_d   = state_q;
    rd_uart   = 1'b0;
    byte_seen = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_empty && !reset) begin
          rd_uart = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        byte_seen = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the FIFO head on the pop edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_reg <= 8'h00;
    end else if (rd_uart) begin
      byte_reg <= rd_data;
    end
  end

  // Compare the captured byte against every player's up/down code.
  always_comb begin
    up_hit  = '0;
    dn_hit  = '0;
    any_hit = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      up_hit[p] = (byte_reg == UP_CODES[8*p +: 8]);
      dn_hit[p] = (byte_reg == DOWN_CODES[8*p +: 8]);
      if (up_hit[p] || dn_hit[p]) begin
        any_hit = 1'b1;
      end
    end
  end

  // Per-player direction and hold counters; a decode load beats a same-cycle
  // tick for that player, and up beats down when both codes coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        hold_q[p] <= 8'h00;
        dir_q[p]  <= 2'b00;
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (decode_en && up_hit[p]) begin
          dir_q[p]  <= 2'b01;
          hold_q[p] <= HOLD_INIT;
        end else if (decode_en && dn_hit[p]) begin
          dir_q[p]  <= 2'b10;
          hold_q[p] <= HOLD_INIT;
        end else if (frame_tick && (hold_q[p] != 8'h00)) begin
          hold_q[p] <= hold_q[p] - 8'h01;
        end
      end
    end
  end

  // Count bytes that matched nothing, sticking at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unknown_cnt <= 8'h00;
    end else if (decode_en && !any_hit && (unknown_cnt != 8'hFF)) begin
      unknown_cnt <= unknown_cnt + 8'h01;
    end
  end

  // Registered key outputs: direction shown only while its hold is live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        keys[2*p +: 2] <= (hold_q[p] != 8'h00) ? dir_q[p] : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_uart_key_mapper.sv
// Bench for uart_key_mapper: a queue-backed FWFT FIFO feeds bytes, a small
// key/hold model predicts keys and unknown_cnt per byte, and a scoreboard
// compares them two edges after each decode pulse.
module tb_uart_key_mapper;

  localparam int NP = 2;
  localparam int W  = 2*NP + 8;

  logic          clk;
  logic          reset;
  logic          rx_empty;
  logic [7:0]    rd_data;
  logic          rd_uart;
  logic          frame_tick;
  logic [2*NP-1:0] keys;
  logic [7:0]    unknown_cnt;
  logic          byte_seen;
  logic          state_dbg;

  uart_key_mapper #(
    .NUM_PLAYERS (NP),
    .UP_CODES    ({8'h69, 8'h77}),
    .DOWN_CODES  ({8'h6B, 8'h73}),
    .HOLD_FRAMES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rd_data     (rd_data),
    .rd_uart     (rd_uart),
    .frame_tick  (frame_tick),
    .keys        (keys),
    .unknown_cnt (unknown_cnt),
    .byte_seen   (byte_seen),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   fifo_q[$];
  logic [7:0]   up_code [NP];
  logic [7:0]   dn_code [NP];
  int           m_hold [NP];
  logic [1:0]   m_dir  [NP];
  int           m_unk;
  int           n_checks;
  int           n_pass;
  int           cyc;
  int           last_pop;
  int           prev_pop;
  bit           have_pop;
  int           pop_cnt;
  int           push_cnt;
  bit           pop_pend;
  bit           bs_d1;
  bit           bs_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [2*NP-1:0] exp_keys();
    logic [2*NP-1:0] k;
    k = '0;
    for (int p = 0; p < NP; p++) begin
      if (m_hold[p] != 0) k[2*p +: 2] = m_dir[p];
    end
    return k;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_hold[p] = 0;
      m_dir[p]  = 2'b00;
    end
    m_unk = 0;
  endtask

  task automatic model_tick();
    for (int p = 0; p < NP; p++) begin
      if (m_hold[p] > 0) m_hold[p]--;
    end
  endtask

  task automatic refresh_fifo();
    rx_empty = (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // ---------------- driver tasks ----------------
  // Queue a byte, predict its effect (with_tick: caller drives a frame tick
  // in the same cycle the byte is decoded) and push the expected outputs.
  task automatic push_byte(input logic [7:0] b, input bit with_tick);
    bit matched;
    matched = 1'b0;
    if (with_tick) model_tick();
    for (int p = 0; p < NP; p++) begin
      if (b == up_code[p]) begin
        m_dir[p] = 2'b01; m_hold[p] = 3; matched = 1'b1;
      end else if (b == dn_code[p]) begin
        m_dir[p] = 2'b10; m_hold[p] = 3; matched = 1'b1;
      end
    end
    if (!matched && m_unk < 255) m_unk++;
    exp_q.push_back({exp_keys(), 8'(m_unk)});
    fifo_q.push_back(b);
    push_cnt++;
  endtask

  // One clock cycle: inputs settle after the falling edge, pops are taken on
  // the rising edge, outputs are sampled on the next falling edge.
  task automatic step(input bit tick);
    frame_tick = tick;
    refresh_fifo();
    #2;
    pop_pend = rd_uart;
    if (rd_uart) begin
      if (have_pop) check("pop_gap_ge2", 32'(cyc - last_pop >= 2), 32'd1);
      prev_pop = last_pop;
      last_pop = cyc;
      have_pop = 1'b1;
      pop_cnt++;
    end
    @(posedge clk);
    #1;
    if (pop_pend) void'(fifo_q.pop_front());
    pop_pend   = 1'b0;
    frame_tick = 1'b0;
    refresh_fifo();
    cyc++;
    @(negedge clk);
    if (bs_d2) begin
      if (exp_q.size() == 0) begin
        check("sb_expected_entry", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_keys", 32'(keys), 32'(e[W-1:8]));
        check("sb_unknown_cnt", 32'(unknown_cnt), 32'(e[7:0]));
      end
    end
    bs_d2 = bs_d1;
    bs_d1 = byte_seen;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || bs_d1 || bs_d2) && n < 2000) begin
      step(1'b0);
      n++;
    end
    check({tag, "_drain_left"}, 32'(fifo_q.size() + exp_q.size()), 32'd0);
    check({tag, "_pops"}, 32'(pop_cnt), 32'(push_cnt));
  endtask

  task automatic tick_check(input string tag);
    model_tick();
    step(1'b1);
    step(1'b0);
    check(tag, 32'(keys), 32'(exp_keys()));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rb;
    int         sel;
    int         pops_before;
    up_code[0] = 8'h77; up_code[1] = 8'h69;
    dn_code[0] = 8'h73; dn_code[1] = 8'h6B;
    n_checks = 0; n_pass = 0; cyc = 0;
    last_pop = 0; prev_pop = 0; have_pop = 1'b0;
    pop_cnt = 0; push_cnt = 0; pop_pend = 1'b0;
    bs_d1 = 1'b0; bs_d2 = 1'b0;
    model_reset();
    frame_tick = 1'b0;
    rx_empty   = 1'b1;
    rd_data    = 8'h00;
    reset      = 1'b1;

    // Reset values
    step(1'b0);
    step(1'b0);
    check("rst_keys", 32'(keys), 32'd0);
    check("rst_unknown", 32'(unknown_cnt), 32'd0);
    check("rst_rd_uart", 32'(rd_uart), 32'd0);
    check("rst_byte_seen", 32'(byte_seen), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step(1'b0);

    // Single up byte for player 0, held through two ticks, gone on the third
    push_byte(8'h77, 1'b0);
    drain("w_single");
    check("w_keys", 32'(keys), 32'h1);
    tick_check("w_tick1");
    tick_check("w_tick2");
    tick_check("w_tick3");
    check("w_released", 32'(keys), 32'h0);

    // Back-to-back bytes: pops two cycles apart
    push_byte(8'h73, 1'b0);
    push_byte(8'h69, 1'b0);
    drain("b2b");
    check("b2b_pop_spacing", 32'(last_pop - prev_pop), 32'd2);
    check("b2b_keys", 32'(keys), 32'h6);

    // Up then down for player 0 before any tick: direction replaced, hold reloaded
    push_byte(8'h77, 1'b0);
    push_byte(8'h73, 1'b0);
    drain("flip");
    tick_check("flip_tick1");
    tick_check("flip_tick2");
    check("flip_still_down", 32'(keys[1:0]), 32'h2);
    tick_check("flip_tick3");

    // Player 1 load coincident with a tick while player 0 hold is 2
    push_byte(8'h77, 1'b0);
    drain("coin_setup");
    tick_check("coin_p0_hold2");
    push_byte(8'h69, 1'b1);
    step(1'b0);
    check("coin_in_decode", 32'(byte_seen), 32'd1);
    step(1'b1);
    drain("coin");
    check("coin_keys", 32'(keys), 32'h5);
    tick_check("coin_tick_a");
    check("coin_p0_gone", 32'(keys), 32'h4);
    tick_check("coin_tick_b");
    tick_check("coin_tick_c");

    // Randomised mix of codes and arbitrary bytes, ticks between them
    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: rb = up_code[0];
        1: rb = up_code[1];
        2: rb = dn_code[0];
        3: rb = dn_code[1];
        default: rb = 8'($urandom_range(0, 255));
      endcase
      push_byte(rb, 1'b0);
      drain("rand");
      if ($urandom_range(0, 1) == 1) tick_check("rand_tick");
    end
    tick_check("flush_tick1");
    tick_check("flush_tick2");
    tick_check("flush_tick3");

    // Unknown byte flood: counter saturates, keys untouched
    for (int i = 0; i < 300; i++) push_byte(8'h41, 1'b0);
    drain("flood");
    check("flood_unknown_sat", 32'(unknown_cnt), 32'd255);
    check("flood_keys", 32'(keys), 32'h0);

    // Reset while a captured 0x77 is being decoded
    fifo_q.push_back(8'h77);
    push_cnt++;
    step(1'b0);
    check("rstdec_in_decode", 32'(byte_seen), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rstdec_state", 32'(state_dbg), 32'd0);
    check("rstdec_byte_seen", 32'(byte_seen), 32'd0);
    check("rstdec_rd_uart", 32'(rd_uart), 32'd0);
    bs_d1 = 1'b0;
    bs_d2 = 1'b0;
    model_reset();
    step(1'b0);
    step(1'b0);
    check("rstdec_unknown", 32'(unknown_cnt), 32'd0);
    reset = 1'b0;
    pops_before = pop_cnt;
    for (int i = 0; i < 6; i++) step(1'b0);
    check("rstdec_keys", 32'(keys), 32'h0);
    check("rstdec_idle", 32'(state_dbg), 32'd0);
    check("rstdec_no_pop", 32'(pop_cnt), 32'(pops_before));
    check("rstdec_unknown_after", 32'(unknown_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
